// File: rtl/grf_scoreboard.sv
// grf_scoreboard: general-purpose register file with same-cycle write-back
// bypass and a per-register pending-write scoreboard for RAW hazard stalls.
// Optional build macro GRF_TRACE_EN: prints one trace line per committed
// write ("@<wpc>: $<wa> <= <wd>"); without it wpc is ignored.
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [31:0]       wpc,
  input  logic              clr,
  output logic              err
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  logic [DATA_W-1:0] regs      [NREG];
  logic [PEND_W-1:0] pend      [NREG];
  logic [PEND_W-1:0] pend_next [NREG];
  logic              commit;
  logic              accept;
  logic              underflow;

  // Read value seen by decode: $0 is hard zero, a retiring write wins over the array.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (a == ADDR_ZERO) begin
      v = DATA_ZERO;
    end else if (we && (wa == a)) begin
      v = wd;
    end else begin
      v = regs[a];
    end
    return v;
  endfunction

  // Hazard flag: the write retiring this cycle is already covered by the bypass.
  function automatic logic busy_port(input logic [ADDR_W-1:0] a);
    logic b;
    if (a == ADDR_ZERO) begin
      b = 1'b0;
    end else if (we && (wa == a)) begin
      b = (pend[a] > PEND_ONE);
    end else begin
      b = (pend[a] != PEND_ZERO);
    end
    return b;
  endfunction

  // Decode-side combinational outputs and the write-back/issue qualifiers.
  always_comb begin
    rd1       = read_port(ra1);
    rd2       = read_port(ra2);
    busy1     = busy_port(ra1);
    busy2     = busy_port(ra2);
    iss_ready = (iss_addr == ADDR_ZERO) || (pend[iss_addr] != PEND_MAX);
    accept    = iss_valid && iss_ready && !clr;
    commit    = we && (wa != ADDR_ZERO);
    underflow = commit && (pend[wa] == PEND_ZERO) && !clr;
  end

  // Next pending count per register: flush clears, otherwise +issue -retire.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_next[r] = pend[r];
      if (r == 0) begin
        pend_next[r] = PEND_ZERO;
      end else if (clr) begin
        pend_next[r] = PEND_ZERO;
      end else begin
        pend_next[r] = pend[r]
                     + PEND_W'(accept && (iss_addr == ADDR_W'(r)))
                     - PEND_W'(we && (wa == ADDR_W'(r)) && (pend[r] != PEND_ZERO));
      end
    end
  end

  // Register array: cleared by reset, written by write-back (never $0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= DATA_ZERO;
      end
    end else if (commit) begin
      regs[wa] <= wd;
    end
  end

  // Scoreboard counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        pend[i] <= PEND_ZERO;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        pend[i] <= pend_next[i];
      end
    end
  end

  // Sticky error: a retire arrived for a register with nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (underflow) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

`ifdef GRF_TRACE_EN
  // Trace of every committed write-back.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      $display("@%h: $%d <= %h", wpc, wa, wd);
    end
  end
`else
  logic unused_wpc;
  assign unused_wpc = ^wpc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
`timescale 1ns/1ps
// tb_grf_scoreboard: directed test-plan scenarios plus randomized traffic,
// checked against an array-based reference model of the register file.
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, iss_addr, wa;
  logic [31:0] rd1, rd2, wd, wpc;
  logic        busy1, busy2, iss_valid, iss_ready, we, clr, err;

  int nchecks = 0;
  int nfail   = 0;

  // Reference model state
  logic [31:0] mreg  [32];
  int          mpend [32];
  bit          merr;

  grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .PEND_W(2)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(iss_ready), .we(we), .wa(wa), .wd(wd), .wpc(wpc), .clr(clr),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return mpend[a] > ((we && wa == a) ? 1 : 0);
  endfunction

  function automatic logic exp_ready();
    return (iss_addr == 5'd0) || (mpend[iss_addr] != 3);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = 32'd0;
      mpend[i] = 0;
    end
    merr = 1'b0;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_addr = 5'd0; we = 1'b0; wa = 5'd0;
    wd = 32'd0; wpc = 32'd0; clr = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, cross the edge.
  task automatic cycle();
    bit acc, dec;
    @(negedge clk);
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("busy1", {31'd0, busy1}, {31'd0, exp_busy(ra1)});
    chk("busy2", {31'd0, busy2}, {31'd0, exp_busy(ra2)});
    chk("iss_ready", {31'd0, iss_ready}, {31'd0, exp_ready()});
    chk("err", {31'd0, err}, {31'd0, merr});
    acc = iss_valid && exp_ready() && !clr;
    dec = we && wa != 5'd0 && mpend[wa] > 0;
    if (we && wa != 5'd0 && mpend[wa] == 0 && !clr) merr = 1'b1;
    if (we && wa != 5'd0) mreg[wa] = wd;
    if (clr) begin
      for (int i = 0; i < 32; i++) mpend[i] = 0;
    end else begin
      if (dec) mpend[wa] = mpend[wa] - 1;
      if (acc && iss_addr != 5'd0) mpend[iss_addr] = mpend[iss_addr] + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ra1 = 5'd0; ra2 = 5'd0;
    idle();
    model_reset();
    #2;
    // Reset state on every address
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a); iss_addr = 5'(a);
      #1;
      chk("rst_rd1", rd1, 32'd0);
      chk("rst_busy1", {31'd0, busy1}, 32'd0);
      chk("rst_ready", {31'd0, iss_ready}, 32'd1);
      chk("rst_err", {31'd0, err}, 32'd0);
    end
    idle();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // $0 is hard-wired to zero
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0;
    #1 chk("r0_bypass", rd1, 32'd0);
    cycle();
    idle(); ra1 = 5'd0;
    #1 chk("r0_read", rd1, 32'd0);
    cycle();

    // Issue $5, busy, retire with same-cycle bypass
    iss_valid = 1'b1; iss_addr = 5'd5; cycle();
    idle(); ra1 = 5'd5;
    #1 chk("r5_busy", {31'd0, busy1}, 32'd1);
    cycle();
    we = 1'b1; wa = 5'd5; wd = 32'h1234;
    #1 chk("r5_bypass", rd1, 32'h1234);
    chk("r5_busy_clr", {31'd0, busy1}, 32'd0);
    cycle();
    idle();
    #1 chk("r5_array", rd1, 32'h1234);
    chk("r5_free", {31'd0, busy1}, 32'd0);
    cycle();

    // Saturate $3
    for (int k = 0; k < 3; k++) begin
      iss_valid = 1'b1; iss_addr = 5'd3; cycle();
    end
    #1 chk("r3_sat", {31'd0, iss_ready}, 32'd0);
    cycle();  // fourth issue ignored
    idle(); ra1 = 5'd3;
    for (int k = 0; k < 3; k++) begin
      we = 1'b1; wa = 5'd3; wd = 32'(k + 100); cycle();
    end
    idle(); iss_addr = 5'd3;
    #1 chk("r3_drained", {31'd0, busy1}, 32'd0);
    chk("r3_ready", {31'd0, iss_ready}, 32'd1);
    chk("r3_noerr", {31'd0, err}, 32'd0);
    cycle();
    iss_valid = 1'b1; iss_addr = 5'd3; cycle();
    iss_valid = 1'b1; iss_addr = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h33; cycle();
    idle();
    #1 chk("r3_same", {31'd0, busy1}, 32'd1);
    cycle();
    we = 1'b1; wa = 5'd3; wd = 32'h34; cycle();
    idle(); cycle();

    // Flush drops pending and same-cycle issue; later retire underflows
    iss_valid = 1'b1; iss_addr = 5'd7; cycle();
    iss_valid = 1'b1; iss_addr = 5'd8; cycle();
    iss_valid = 1'b1; iss_addr = 5'd9; clr = 1'b1; cycle();
    idle(); ra1 = 5'd7; ra2 = 5'd9;
    #1 chk("clr_b7", {31'd0, busy1}, 32'd0);
    chk("clr_b9", {31'd0, busy2}, 32'd0);
    cycle();
    we = 1'b1; wa = 5'd7; wd = 32'hCAFE; cycle();
    idle();
    #1 chk("uf_err", {31'd0, err}, 32'd1);
    chk("uf_data", rd1, 32'hCAFE);
    cycle();

    // Randomized traffic concentrated on low registers
    for (int n = 0; n < 400; n++) begin
      ra1 = 5'($urandom_range(0, 9));
      ra2 = 5'($urandom_range(0, 31));
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = 5'($urandom_range(0, 9));
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 9));
      wd  = $urandom;
      wpc = $urandom;
      clr = ($urandom_range(0, 19) == 0);
      cycle();
    end

    // Asynchronous reset in the middle of a cycle
    idle(); iss_valid = 1'b1; iss_addr = 5'd4; wa = 5'd4; we = 1'b1; wd = 32'h4444; cycle();
    iss_valid = 1'b1; iss_addr = 5'd4; we = 1'b0; ra1 = 5'd4;
    #1 chk("pre_rst_busy", {31'd0, busy1}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_rd1", rd1, 32'd0);
    chk("arst_busy1", {31'd0, busy1}, 32'd0);
    chk("arst_ready", {31'd0, iss_ready}, 32'd1);
    chk("arst_err", {31'd0, err}, 32'd0);
    model_reset();
    idle();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      ra1 = 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = 5'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
